// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for the in-order integer pipeline.
// It keeps a shifting scoreboard of in-flight writers and derives the stalls and forward selects from it.
module fwd_hazard_ctrl #(
  parameter  int REG_W      = 5,
  parameter  int NUM_SRC    = 2,
  parameter  int DEPTH      = 3,
  parameter  int LOAD_AVAIL = 3,
  parameter  int CNT_W      = 16,
  localparam int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [NUM_SRC*REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]           id_rd,
  input  logic                       id_wen,
  input  logic                       id_is_load,
  input  logic                       id_is_branch,
  input  logic                       flush,
  input  logic                       ext_hold,
  output logic                       hazard_stall,
  output logic [NUM_SRC*SEL_W-1:0]   ex_fwd_sel,
  output logic [NUM_SRC*SEL_W-1:0]   br_fwd_sel,
  output logic [CNT_W-1:0]           stall_count
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             wen;
    logic             is_load;
  } slot_t;

  typedef struct packed {
    logic             hit;
    logic             is_load;
    logic [SEL_W-1:0] k;
  } match_t;

  // Slot 1 is EX, slot DEPTH is WB.
  slot_t slot_q [DEPTH:1];

  logic [NUM_SRC-1:0]       ex_hz;
  logic [NUM_SRC-1:0]       br_hz;
  logic [NUM_SRC*SEL_W-1:0] ex_sel_d;

  // Scan from oldest to youngest so the lowest matching slot is the one kept.
  // The WB slot is skipped: the register file already returns its value.
  function automatic match_t youngest(input logic [REG_W-1:0] r);
    match_t res;
    res = '0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (slot_q[k].valid && slot_q[k].wen && (slot_q[k].rd == r) && (r != '0)) begin
        res.hit     = 1'b1;
        res.is_load = slot_q[k].is_load;
        res.k       = SEL_W'(k);
      end
    end
    return res;
  endfunction

  always_comb begin
    match_t m;
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    m          = '0;
    ex_hz      = '0;
    br_hz      = '0;
    ex_sel_d   = '0;
    br_fwd_sel = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      m = youngest(id_rs[j*REG_W +: REG_W]);
      // By the time this instruction is in EX its producer has moved one slot further.
      if (id_valid && m.hit) begin
        if (m.is_load && (int'(m.k) + 1 < LOAD_AVAIL))
          ex_hz[j] = 1'b1;
        else
          ex_sel_d[j*SEL_W +: SEL_W] = m.k + SEL_W'(1);
      end
      // Branch operands are consumed now, and the EX result is not ready until it leaves EX.
      if (id_valid && id_is_branch && m.hit) begin
        if ((m.k == SEL_W'(1)) || (m.is_load && (int'(m.k) < LOAD_AVAIL)))
          br_hz[j] = 1'b1;
        else
          br_fwd_sel[j*SEL_W +: SEL_W] = m.k;
      end
    end
  end

  assign hazard_stall = id_valid && !flush && !ext_hold && ((|ex_hz) || (|br_hz));

  // NOTE: state is updated with non-blocking assignments only, so the shift reads pre-edge slot values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the scoreboard is a handful of flops, so whole records are cleared, not just valid bits.
      for (int k = 1; k <= DEPTH; k++) slot_q[k] <= '0;
      ex_fwd_sel  <= '0;
      stall_count <= '0;
    end else if (!ext_hold) begin
      for (int k = DEPTH; k >= 2; k--) slot_q[k] <= slot_q[k-1];
      if (flush || hazard_stall || !id_valid) begin
        slot_q[1]  <= '0;
        ex_fwd_sel <= '0;
      end else begin
        slot_q[1]  <= '{valid: 1'b1, rd: id_rd, wen: id_wen, is_load: id_is_load};
        ex_fwd_sel <= ex_sel_d;
      end
      if (hazard_stall && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule
